mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 43 ++++
 rtl/mul_arbiter.sv | 119 +++++++++++
 tb/tb_mul_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
//==============================================================================
// Module      : mul_arbiter_if
// Description : Requester, response and multiplier-control signals of the
//               two-requester multiplier arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mul_arbiter_if #(
    parameter int WIDTH = 32
);
    logic                 req0;
    logic                 req1;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 done0;
    logic                 done1;
    logic [2*WIDTH-1:0]   result;
    logic                 err;
    logic                 st;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   product;
    logic                 mul_valid;

    // Arbiter side
    modport slave (
        input  req0, req1, a0, b0, a1, b1, product, mul_valid,
        output gnt0, gnt1, done0, done1, result, err, st, mcand, mplier
    );

    // Requesters plus multiplier datapath side
    modport master (
        output req0, req1, a0, b0, a1, b1, product, mul_valid,
        input  gnt0, gnt1, done0, done1, result, err, st, mcand, mplier
    );
endinterface

`default_nettype wire

// File: rtl/mul_arbiter.sv
//==============================================================================
// Module      : mul_arbiter
// Description : Round-robin arbiter sharing one multiplier between two
//               requesters, with a timeout abort while waiting for the result.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  wire            i_clk,
    input  wire            i_rst_n,
    mul_arbiter_if.slave   io_bus
);

    localparam int              CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   C_CNT_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_owner;
    logic                   r_last;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_err;

    logic                   w_grant;
    logic                   w_sel;
    logic                   w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        // On a tie the requester that was not served last wins
        w_sel   = (io_bus.req0 && io_bus.req1) ? ~r_last : io_bus.req1;
        case (r_state)
            S_IDLE: begin
                if (io_bus.req0 || io_bus.req1) begin
                    w_grant = 1'b1;
                    w_next  = S_START;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (io_bus.mul_valid || w_cnt_zero) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_sel;
                        r_mcand  <= w_sel ? io_bus.a1 : io_bus.a0;
                        r_mplier <= w_sel ? io_bus.b1 : io_bus.b0;
                    end
                end
                S_START: r_cnt <= C_CNT_LOAD;
                S_WAIT: begin
                    // A valid result wins over an expiring counter
                    if (io_bus.mul_valid) begin
                        r_result <= io_bus.product;
                        r_err    <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_last <= r_owner;
                default: ;
            endcase
        end
    end

    // Pulses are masked while reset is asserted so requests never see a grant
    assign io_bus.gnt0   = i_rst_n & w_grant & ~w_sel;
    assign io_bus.gnt1   = i_rst_n & w_grant &  w_sel;
    assign io_bus.st     = i_rst_n & (r_state == S_START);
    assign io_bus.done0  = i_rst_n & (r_state == S_RESP) & ~r_owner;
    assign io_bus.done1  = i_rst_n & (r_state == S_RESP) &  r_owner;
    assign io_bus.result = r_result;
    assign io_bus.err    = r_err;
    assign io_bus.mcand  = r_mcand;
    assign io_bus.mplier = r_mplier;

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
//==============================================================================
// Module      : tb_mul_arbiter
// Description : Self-checking bench for mul_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mul_arbiter;

    localparam int W  = 32;
    localparam int TO = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_arbiter_if #(.WIDTH(W)) bus ();

    mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: an operation is timed in cycles since its grant
    bit          m_busy  = 1'b0;
    bit          m_resp  = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b1;
    int          m_k     = 0;
    logic [63:0] m_res   = '0;
    bit          m_err   = 1'b0;
    logic [31:0] m_mc    = '0;
    logic [31:0] m_mp    = '0;
    bit          e_g0    = 1'b0;
    bit          e_g1    = 1'b0;

    always @(negedge clk) begin
        bit eg0, eg1, est, ed0, ed1, sel;
        if (mon_en) begin
            eg0 = 0; eg1 = 0; est = 0; ed0 = 0; ed1 = 0; sel = 0;
            if (rst_n) begin
                if (!m_busy) begin
                    if (bus.req0 || bus.req1) begin
                        sel = (bus.req0 && bus.req1) ? !m_last : bus.req1;
                        eg0 = !sel;
                        eg1 = sel;
                    end
                end else begin
                    est = (m_k == 1);
                    ed0 = m_resp && !m_owner;
                    ed1 = m_resp && m_owner;
                end
            end
            chk("gnt0",   64'(bus.gnt0),   64'(eg0));
            chk("gnt1",   64'(bus.gnt1),   64'(eg1));
            chk("st",     64'(bus.st),     64'(est));
            chk("done0",  64'(bus.done0),  64'(ed0));
            chk("done1",  64'(bus.done1),  64'(ed1));
            chk("result", bus.result,      m_res);
            chk("err",    64'(bus.err),    64'(m_err));
            chk("mcand",  64'(bus.mcand),  64'(m_mc));
            chk("mplier", 64'(bus.mplier), 64'(m_mp));
            e_g0 = eg0;
            e_g1 = eg1;
            if (!rst_n) begin
                m_busy = 0; m_resp = 0; m_last = 1; m_res = '0; m_err = 0;
                m_mc = '0; m_mp = '0; m_owner = 0;
            end else if (!m_busy) begin
                if (eg0 || eg1) begin
                    m_busy = 1; m_resp = 0; m_k = 1; m_owner = eg1;
                    m_mc = eg1 ? bus.a1 : bus.a0;
                    m_mp = eg1 ? bus.b1 : bus.b0;
                end
            end else if (m_resp) begin
                m_busy = 0;
                m_last = m_owner;
            end else begin
                if (m_k >= 2) begin
                    if (bus.mul_valid) begin
                        m_res = bus.product; m_err = 0; m_resp = 1;
                    end else if (m_k == TO + 1) begin
                        m_res = '0; m_err = 1; m_resp = 1;
                    end
                end
                m_k++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int gq[$];
    int dq[$];
    int n;

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.product = '0; bus.mul_valid = 0;
        rst_n = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        rst_n = 1'b1;

        // Single request, result 33 cycles after St
        tick();
        bus.req0 = 1; bus.a0 = 6; bus.b0 = 7;
        obs(); chk("t1_gnt0", 64'(bus.gnt0), 64'd1);
        tick(); bus.req0 = 0;
        obs(); chk("t1_st", 64'(bus.st), 64'd1);
        repeat (32) tick();
        tick(); bus.mul_valid = 1; bus.product = 64'd42;
        tick(); bus.mul_valid = 0;
        obs();
        chk("t1_done0",  64'(bus.done0), 64'd1);
        chk("t1_result", bus.result, 64'd42);
        chk("t1_err",    64'(bus.err), 64'd0);

        // Tie after reset alternates 0,1,0
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        bus.a0 = 3; bus.b0 = 5; bus.a1 = 7; bus.b1 = 9;
        bus.mul_valid = 1; bus.product = 64'd100;
        for (int i = 0; i < 16; i++) begin
            obs();
            if (bus.gnt0)  gq.push_back(0);
            if (bus.gnt1)  gq.push_back(1);
            if (bus.done0) dq.push_back(0);
            if (bus.done1) dq.push_back(1);
            tick();
        end
        bus.req0 = 0; bus.req1 = 0; bus.mul_valid = 0;
        chk("t2_ngrants", 64'(gq.size()), 64'd4);
        chk("t2_ndones",  64'(dq.size()), 64'd4);
        if (gq.size() >= 3) begin
            chk("t2_g0", 64'(gq[0]), 64'd0);
            chk("t2_g1", 64'(gq[1]), 64'd1);
            chk("t2_g2", 64'(gq[2]), 64'd0);
        end
        if (dq.size() >= 3) begin
            chk("t2_d0", 64'(dq[0]), 64'd0);
            chk("t2_d1", 64'(dq[1]), 64'd1);
            chk("t2_d2", 64'(dq[2]), 64'd0);
        end
        repeat (3) tick();

        // Timeout: Done1 exactly 41 cycles after St
        bus.req1 = 1;
        obs(); chk("t3_gnt1", 64'(bus.gnt1), 64'd1);
        tick(); bus.req1 = 0;
        obs(); chk("t3_st", 64'(bus.st), 64'd1);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(); obs();
            if (bus.done1) begin
                n = i;
                break;
            end
        end
        chk("t3_latency", 64'(n), 64'd41);
        chk("t3_err",     64'(bus.err), 64'd1);
        chk("t3_result",  bus.result, 64'd0);
        repeat (2) tick();

        // Valid arrives in the same cycle the counter expires
        bus.req1 = 1;
        obs(); chk("t4_gnt1", 64'(bus.gnt1), 64'd1);
        tick(); bus.req1 = 0;
        repeat (39) tick();
        tick(); bus.mul_valid = 1; bus.product = 64'hFFFF_FFFE_0000_0001;
        tick(); bus.mul_valid = 0;
        obs();
        chk("t4_done1",  64'(bus.done1), 64'd1);
        chk("t4_err",    64'(bus.err), 64'd0);
        chk("t4_result", bus.result, 64'hFFFF_FFFE_0000_0001);
        repeat (2) tick();

        // Reset in the middle of WAIT with Req1 held
        bus.req1 = 1; bus.a1 = 11; bus.b1 = 13;
        obs(); chk("t5_gnt1", 64'(bus.gnt1), 64'd1);
        repeat (4) tick();
        tick(); rst_n = 0;
        obs();
        chk("t5_rst_gnt1",  64'(bus.gnt1), 64'd0);
        chk("t5_rst_done1", 64'(bus.done1), 64'd0);
        tick(); rst_n = 1;
        obs();
        chk("t5_regrant", 64'(bus.gnt1), 64'd1);
        chk("t5_nodone",  64'(bus.done1), 64'd0);
        chk("t5_result",  bus.result, 64'd0);
        tick(); bus.req1 = 0;
        tick(); bus.mul_valid = 1; bus.product = 64'd123;
        tick(); bus.mul_valid = 0;
        obs();
        chk("t5_done1",   64'(bus.done1), 64'd1);
        chk("t5_result2", bus.result, 64'd123);

        // Spurious MulValid in IDLE
        repeat (2) tick();
        bus.mul_valid = 1; bus.product = 64'd999;
        obs();
        chk("t6_done0", 64'(bus.done0), 64'd0);
        chk("t6_done1", 64'(bus.done1), 64'd0);
        tick(); bus.mul_valid = 0;
        obs();
        chk("t6_result", bus.result, 64'd123);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst_n     = ($urandom % 400) != 0;
            bus.req0  = (bus.req0 && !e_g0) ? 1'b1 : (($urandom % 3) == 0);
            bus.req1  = (bus.req1 && !e_g1) ? 1'b1 : (($urandom % 3) == 0);
            bus.a0    = $urandom; bus.b0 = $urandom;
            bus.a1    = $urandom; bus.b1 = $urandom;
            bus.mul_valid = ($urandom % 25) == 0;
            bus.product   = {$urandom, $urandom};
        end
        tick();
        rst_n = 1;
        obs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
